// File: rtl/err_stats_gen.sv
// Windowed error statistics: sum of squares and signed DC sum over 2^WIN_LOG2 samples.
// Two-stage pipeline (square, then accumulate); results land one clk after the window's final add.
`ifndef LFSR_LEN
`define LFSR_LEN 10
`endif

module err_stats_gen #(
  parameter int ERR_W    = 18,
  parameter int WIN_LOG2 = `LFSR_LEN
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clk_en,
  input  logic signed [ERR_W-1:0]          err,
  input  logic                             start,
  input  logic                             cont,
  input  logic                             abort,
  output logic [ERR_W+WIN_LOG2-1:0]        acc_sq_err_out,
  output logic signed [ERR_W+WIN_LOG2-1:0] acc_err_out,
  output logic                             done,
  output logic                             busy
);

  localparam int ACC_W  = ERR_W + WIN_LOG2;
  localparam int PROD_W = 2 * ERR_W;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DUMP} state_t;

  state_t                    state_q, state_d;
  logic [WIN_LOG2-1:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0]          sq_reg_q;
  logic signed [ERR_W-1:0]   e_reg_q;
  logic                      v1_q;
  logic [ACC_W-1:0]          sq_acc_q;
  logic signed [ACC_W-1:0]   dc_acc_q;
  logic [ACC_W-1:0]          sq_out_q;
  logic signed [ACC_W-1:0]   dc_out_q;
  logic                      done_q;

  logic                      dump;
  logic                      win_start;
  logic signed [PROD_W-1:0]  prod;
  logic [ERR_W-1:0]          sq_w;

  // Keep the Q1 alignment: drop the duplicated sign bit and the low ERR_W-1 fraction bits.
  assign prod = PROD_W'(err) * PROD_W'(err);
  assign sq_w = ERR_W'(prod >> (ERR_W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (clk_en && start) state_d = ACCUM;
        ACCUM:   if (clk_en && (&cnt_q)) state_d = FLUSH;
        FLUSH:   if (clk_en) state_d = DUMP;
        DUMP:    state_d = cont ? ACCUM : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    dump      = (state_q == DUMP) && !abort;
    win_start = !abort && (((state_q == IDLE) && clk_en && start) ||
                           ((state_q == DUMP) && cont));
  end

  always_comb begin
    cnt_d = cnt_q;
    if (abort || win_start) begin
      cnt_d = '0;
    end else if ((state_q == ACCUM) && clk_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      sq_reg_q <= '0;
      e_reg_q  <= '0;
      v1_q     <= 1'b0;
      sq_acc_q <= '0;
      dc_acc_q <= '0;
      sq_out_q <= '0;
      dc_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= dump;

      if (clk_en) begin
        sq_reg_q <= sq_w;
        e_reg_q  <= err;
      end

      if (abort || dump) begin
        v1_q <= 1'b0;
      end else if (clk_en) begin
        v1_q <= (state_q == ACCUM);
      end

      // The add still in flight from the last sample is completed by the FLUSH clk_en.
      if (abort || dump) begin
        sq_acc_q <= '0;
        dc_acc_q <= '0;
      end else if (clk_en && v1_q) begin
        sq_acc_q <= sq_acc_q + ACC_W'(sq_reg_q);
        dc_acc_q <= dc_acc_q + ACC_W'(e_reg_q);
      end

      if (dump) begin
        sq_out_q <= sq_acc_q;
        dc_out_q <= dc_acc_q;
      end
    end
  end

  assign acc_sq_err_out = sq_out_q;
  assign acc_err_out    = dc_out_q;
  assign done           = done_q;

endmodule

// File: doc/err_stats_gen.md
ERR_STATS_GEN -- requirements
Module: err_stats_gen

Interface
- REQ-001 SHALL have parameter ERR_W, default 18: error sample width, signed Q1.(ERR_W-1).
- REQ-002 SHALL have parameter WIN_LOG2, default `LFSR_LEN`: log2 of the window length N = 2^WIN_LOG2 samples.
- REQ-003 SHALL derive local parameter ACC_W = ERR_W + WIN_LOG2.
- REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
- REQ-005 SHALL have port reset, input, 1: asynchronous, active-high; clears all state.
- REQ-006 SHALL have port clk_en, input, 1: sample strobe; one sample per clk cycle with clk_en high.
- REQ-007 SHALL have port err, input, signed [ERR_W-1:0]: error sample.
- REQ-008 SHALL have port start, input, 1: arms one window; sampled on clk_en cycles in IDLE only.
- REQ-009 SHALL have port cont, input, 1: continuous mode; sampled in DUMP.
- REQ-010 SHALL have port abort, input, 1: synchronous cancel; no qualification by clk_en.
- REQ-011 SHALL have port acc_sq_err_out, output, unsigned [ACC_W-1:0]: last completed window's sum of squares.
- REQ-012 SHALL have port acc_err_out, output, signed [ACC_W-1:0]: last completed window's signed error sum (DC).
- REQ-013 SHALL have port done, output, 1: one-clk pulse when the outputs update.
- REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
- REQ-015 SHALL implement the states IDLE, ACCUM, FLUSH and DUMP.
- REQ-016 SHALL move IDLE->ACCUM on a clk_en cycle with start=1; the sample count SHALL clear to 0 on that edge.
- REQ-017 In ACCUM, each clk_en cycle SHALL take one sample and increment the count; the cycle with count==N-1 SHALL move the FSM to FLUSH.
- REQ-018 Stage 1, on each clk_en: sq_reg <= bits [2*ERR_W-2:ERR_W-1] of err*err (unsigned, ERR_W bits); e_reg <= err; v1 <= (state==ACCUM).
- REQ-019 Stage 2, on each clk_en with v1=1: sq_acc <= sq_acc + sq_reg and dc_acc <= dc_acc + sign-extended e_reg, both ACC_W bits; overflow is impossible by width.
- REQ-020 FLUSH SHALL move to DUMP on the next clk_en, which carries the final stage-2 add.
- REQ-021 DUMP SHALL last exactly one clk, not gated by clk_en.
- REQ-022 In DUMP: the outputs SHALL load from sq_acc/dc_acc, done SHALL go high for that clk, sq_acc, dc_acc and v1 SHALL clear, and the next state SHALL be ACCUM if cont=1, else IDLE.
- REQ-023 Samples presented during FLUSH/DUMP SHALL NOT be accumulated; in cont mode with clk_en held high this drops 2 samples per window.
- REQ-024 start outside IDLE SHALL be ignored.
- REQ-025 abort=1 in any state SHALL give, at the next edge: state IDLE, count/sq_acc/dc_acc/v1 cleared, no done, outputs unchanged; abort SHALL win over simultaneous start or DUMP.
- REQ-026 Outputs SHALL hold their values between done pulses.

Reset
- REQ-027 Asynchronous reset SHALL force: state IDLE, count 0, sq_reg 0, e_reg 0, v1 0, sq_acc 0, dc_acc 0, acc_sq_err_out 0, acc_err_out 0, done 0, busy 0.
- REQ-028 Reset mid-window SHALL discard partial sums; no done SHALL follow.

Verification (WIN_LOG2=2, N=4, ERR_W=18, clk_en=1 unless stated)
- REQ-029 start at edge 0, err=65536 (+0.5) -> busy from edge 0; done high only after edge 6; acc_sq_err_out=131072; acc_err_out=262144; then IDLE.
- REQ-030 err=-131072 (-1.0) window -> acc_sq_err_out=524288 (4x131072, no overflow); acc_err_out=-524288.
- REQ-031 clk_en one cycle in three, err alternating +65536/-65536 -> acc_sq_err_out=131072; acc_err_out=0; exactly one done pulse.
- REQ-032 cont=1, err=65536 -> done every 6 clks; each window=131072; busy never drops.
- REQ-033 abort after 2 samples -> IDLE next edge, no done; outputs keep prior values; a new start gives a clean 4-sample result.
- REQ-034 reset asserted mid-ACCUM between clock edges -> all outputs 0 at once; start after release -> correct result.
